// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache (fetch stage <-> memory controller).
// Latency: hit returns if_valid the cycle after the request; a miss returns the cycle after mc_valid.
// Backpressure: if_ready low for the whole miss; rdy low freezes every register, mc_valid ignored.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global ready; low pauses the whole block
//   if_req/if_pc        fetch request and address (pc[1:0] ignored), sampled when if_ready=1
//   if_clear            fetch redirect; drops the current request or any outstanding response
//   if_ready            high in IDLE (combinational from state)
//   if_valid/if_instr   one-cycle response pulse and instruction word
//   mc_fet_ena/mc_addr  registered single-word fetch to the memory controller, held until mc_valid
//   mc_valid/mc_data    one-cycle fill pulse and word from the memory controller
//
// Build option: define ICACHE_BYPASS_EN to drop the arrays; every request then takes the miss path.

module icache #(
   parameter int INDEX_WIDTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        if_req,
   input  logic [31:0] if_pc,
   input  logic        if_clear,
   output logic        if_ready,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic        mc_fet_ena,
   output logic [31:0] mc_addr,
   input  logic        mc_valid,
   input  logic [31:0] mc_data
);

   localparam int LINES = 1 << INDEX_WIDTH;
   localparam int TAG_W = 30 - INDEX_WIDTH;

   typedef enum logic {
      IDLE = 1'b0,
      MISS = 1'b1
   } state_t;

   state_t      state, state_n;
   logic        if_valid_n;
   logic [31:0] if_instr_n;
   logic        mc_fet_ena_n;
   logic [31:0] mc_addr_n;
   logic [31:0] pend_pc, pend_pc_n;
   logic        drop, drop_n;
   logic        fill;
   logic        hit;
   logic [31:0] hit_data;
   logic        unused_bits;

   assign if_ready = (state == IDLE);

   // ------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------
`ifdef ICACHE_BYPASS_EN
   assign hit      = 1'b0;
   assign hit_data = '0;
   assign unused_bits = ^{if_pc[1:0], pend_pc, fill};
`else
   logic [LINES-1:0]       valid_q;
   logic [TAG_W-1:0]       tag_q  [LINES];
   logic [31:0]            data_q [LINES];
   logic [INDEX_WIDTH-1:0] req_idx, fill_idx;
   logic [TAG_W-1:0]       req_tag, fill_tag;

   assign req_idx  = if_pc[INDEX_WIDTH+1:2];
   assign req_tag  = if_pc[31:INDEX_WIDTH+2];
   assign fill_idx = pend_pc[INDEX_WIDTH+1:2];
   assign fill_tag = pend_pc[31:INDEX_WIDTH+2];

   // Asynchronous array read; the result is captured into if_instr, so a
   // request the cycle after a fill already sees the new line.
   assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign hit_data = data_q[req_idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (rdy && fill) begin
         valid_q[fill_idx] <= 1'b1;
      end
   end

   // Tags and data carry no reset; the valid bits alone qualify them.
   always_ff @(posedge clk) begin
      if (!rst && rdy && fill) begin
         tag_q[fill_idx]  <= fill_tag;
         data_q[fill_idx] <= mc_data;
      end
   end

   assign unused_bits = ^{if_pc[1:0], pend_pc[1:0]};
`endif

   // ------------------------------------------------------------------
   // Control FSM: next-state and next-output logic
   // ------------------------------------------------------------------
   always_comb begin
      state_n      = state;
      if_valid_n   = 1'b0;          // pulse: low unless set below
      if_instr_n   = if_instr;
      mc_fet_ena_n = mc_fet_ena;
      mc_addr_n    = mc_addr;
      pend_pc_n    = pend_pc;
      drop_n       = drop;
      fill         = 1'b0;

      unique case (state)
         IDLE: begin
            if (if_req && !if_clear) begin
               if (hit) begin
                  if_valid_n = 1'b1;
                  if_instr_n = hit_data;
               end else begin
                  pend_pc_n    = {if_pc[31:2], 2'b00};
                  mc_addr_n    = {if_pc[31:2], 2'b00};
                  mc_fet_ena_n = 1'b1;
                  drop_n       = 1'b0;
                  state_n      = MISS;
               end
            end
         end
         MISS: begin
            // The controller cannot abort, so a redirect only marks the
            // eventual response for discarding.
            if (if_clear) begin
               drop_n = 1'b1;
            end
            if (mc_valid) begin
               fill         = 1'b1;
               mc_fet_ena_n = 1'b0;
               state_n      = IDLE;
               if_valid_n   = !drop && !if_clear;
               if_instr_n   = mc_data;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // State and output registers; rdy low holds everything
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         if_valid   <= 1'b0;
         if_instr   <= '0;
         mc_fet_ena <= 1'b0;
         mc_addr    <= '0;
         pend_pc    <= '0;
         drop       <= 1'b0;
      end else if (rdy) begin
         state      <= state_n;
         if_valid   <= if_valid_n;
         if_instr   <= if_instr_n;
         mc_fet_ena <= mc_fet_ena_n;
         mc_addr    <= mc_addr_n;
         pend_pc    <= pend_pc_n;
         drop       <= drop_n;
      end
   end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: expected instruction words are queued when a
// request is driven and popped by a monitor whenever if_valid pulses.
// Inputs change 1 time unit after the rising edge; outputs are sampled then or on the falling edge.

module tb_icache;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        if_req;
   logic [31:0] if_pc;
   logic        if_clear;
   logic        if_ready;
   logic        if_valid;
   logic [31:0] if_instr;
   logic        mc_fet_ena;
   logic [31:0] mc_addr;
   logic        mc_valid;
   logic [31:0] mc_data;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [31:0] sb[$];

   always #5 clk = ~clk;

   icache #(.INDEX_WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .rdy        (rdy),
      .if_req     (if_req),
      .if_pc      (if_pc),
      .if_clear   (if_clear),
      .if_ready   (if_ready),
      .if_valid   (if_valid),
      .if_instr   (if_instr),
      .mc_fet_ena (mc_fet_ena),
      .mc_addr    (mc_addr),
      .mc_valid   (mc_valid),
      .mc_data    (mc_data)
   );

   // Response monitor: each counted if_valid pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && rdy && if_valid) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_if_valid: got if_valid=1 instr=%h, required no response", if_instr);
         end else begin
            logic [31:0] exp_w;
            exp_w = sb.pop_front();
            if (if_instr !== exp_w) begin
               n_fail++;
               $display("FAIL if_instr: got %h, required %h", if_instr, exp_w);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one request when the cache is idle; returns 1 unit after the sampling edge.
   task automatic req(input logic [31:0] pc);
      int k;
      k = 0;
      while (!if_ready && k < 50) begin
         step();
         k++;
      end
      if (!if_ready) begin
         n_cmp++;
         n_fail++;
         $display("FAIL req_wait_ready: got if_ready=0 after %0d cycles, required 1", k);
      end
      if_req = 1'b1;
      if_pc  = pc;
      step();
      if_req = 1'b0;
   endtask

   // Memory controller response after wait_cyc idle cycles.
   task automatic fill(input logic [31:0] d, input int wait_cyc);
      repeat (wait_cyc) step();
      mc_valid = 1'b1;
      mc_data  = d;
      step();
      mc_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      step();
      n_cmp++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain: got %0d pending responses, required 0", name, sb.size());
      end
      sb.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1; rdy = 1'b1; if_req = 1'b0; if_pc = '0; if_clear = 1'b0;
      mc_valid = 1'b0; mc_data = '0;
      step(); step();
      rst = 1'b0;
      n_cmp++; if (if_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_if_ready: got %b, required 1", if_ready); end
      n_cmp++; if (if_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_if_valid: got %b, required 0", if_valid); end
      n_cmp++; if (if_instr !== 32'h0)  begin n_fail++; $display("FAIL reset_if_instr: got %h, required 0", if_instr); end
      n_cmp++; if (mc_fet_ena !== 1'b0) begin n_fail++; $display("FAIL reset_mc_fet_ena: got %b, required 0", mc_fet_ena); end
      n_cmp++; if (mc_addr !== 32'h0)   begin n_fail++; $display("FAIL reset_mc_addr: got %h, required 0", mc_addr); end
   endtask

   task automatic test_cold_miss();
      sb.push_back(32'h00A0_0093);
      req(32'h0000_1004);
      n_cmp++; if (mc_fet_ena !== 1'b1)        begin n_fail++; $display("FAIL cold_fet_ena: got %b, required 1", mc_fet_ena); end
      n_cmp++; if (mc_addr !== 32'h0000_1004)  begin n_fail++; $display("FAIL cold_mc_addr: got %h, required 00001004", mc_addr); end
      n_cmp++; if (if_ready !== 1'b0)          begin n_fail++; $display("FAIL cold_if_ready: got %b, required 0", if_ready); end
      fill(32'h00A0_0093, 2);
      n_cmp++; if (if_valid !== 1'b1)          begin n_fail++; $display("FAIL cold_if_valid: got %b, required 1", if_valid); end
      n_cmp++; if (mc_fet_ena !== 1'b0)        begin n_fail++; $display("FAIL cold_fet_drop: got %b, required 0", mc_fet_ena); end
      n_cmp++; if (if_ready !== 1'b1)          begin n_fail++; $display("FAIL cold_ready_back: got %b, required 1", if_ready); end
      drain("cold");
   endtask

   task automatic test_hit();
      sb.push_back(32'h00A0_0093);
      req(32'h0000_1007);    // low bits ignored: same word
      n_cmp++; if (if_valid !== 1'b1)   begin n_fail++; $display("FAIL hit_if_valid: got %b, required 1", if_valid); end
      n_cmp++; if (mc_fet_ena !== 1'b0) begin n_fail++; $display("FAIL hit_no_fetch: got %b, required 0", mc_fet_ena); end
      drain("hit");
   endtask

   task automatic test_conflict();
      sb.push_back(32'h1111_2222);
      req(32'h0000_1404);
      n_cmp++; if (mc_fet_ena !== 1'b1 || mc_addr !== 32'h0000_1404) begin
         n_fail++; $display("FAIL conflict_miss2: got ena=%b addr=%h, required 1/00001404", mc_fet_ena, mc_addr);
      end
      fill(32'h1111_2222, 1);
      // Back-to-back: new line is visible the cycle right after the fill.
      sb.push_back(32'h1111_2222);
      req(32'h0000_1404);
      n_cmp++; if (mc_fet_ena !== 1'b0) begin n_fail++; $display("FAIL conflict_refill_hit: got ena=%b, required 0", mc_fet_ena); end
      sb.push_back(32'h00A0_0093);
      req(32'h0000_1004);
      n_cmp++; if (mc_fet_ena !== 1'b1 || mc_addr !== 32'h0000_1004) begin
         n_fail++; $display("FAIL conflict_miss3: got ena=%b addr=%h, required 1/00001004", mc_fet_ena, mc_addr);
      end
      fill(32'h00A0_0093, 0);
      drain("conflict");
   endtask

   task automatic test_clear();
      req(32'h0000_2008);
      step(); step();
      if_clear = 1'b1;
      step();
      if_clear = 1'b0;
      n_cmp++; if (mc_fet_ena !== 1'b1 || mc_addr !== 32'h0000_2008) begin
         n_fail++; $display("FAIL clear_hold: got ena=%b addr=%h, required 1/00002008", mc_fet_ena, mc_addr);
      end
      fill(32'hDEAD_BEEF, 1);
      n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL clear_dropped: got if_valid=%b, required 0", if_valid); end
      sb.push_back(32'hDEAD_BEEF);
      req(32'h0000_2008);
      n_cmp++; if (mc_fet_ena !== 1'b0) begin n_fail++; $display("FAIL clear_then_hit: got ena=%b, required 0", mc_fet_ena); end
      drain("clear_hit");
      // Clear coincident with a request in IDLE drops it.
      if_clear = 1'b1;
      req(32'h0000_2008);
      if_clear = 1'b0;
      n_cmp++; if (if_valid !== 1'b0 || mc_fet_ena !== 1'b0) begin
         n_fail++; $display("FAIL clear_idle: got valid=%b ena=%b, required 0/0", if_valid, mc_fet_ena);
      end
      // Clear in the same cycle as mc_valid: line fills, response suppressed.
      req(32'h0000_300C);
      if_clear = 1'b1;
      fill(32'h3333_3333, 1);
      if_clear = 1'b0;
      n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL clear_at_fill: got if_valid=%b, required 0", if_valid); end
      sb.push_back(32'h3333_3333);
      req(32'h0000_300C);
      n_cmp++; if (mc_fet_ena !== 1'b0) begin n_fail++; $display("FAIL clear_at_fill_hit: got ena=%b, required 0", mc_fet_ena); end
      drain("clear");
   endtask

   task automatic test_pause();
      req(32'h0000_4010);
      rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin mc_valid = 1'b1; mc_data = 32'hBAD0_BAD0; end
         else mc_valid = 1'b0;
         step();
         n_cmp++; if (mc_fet_ena !== 1'b1 || mc_addr !== 32'h0000_4010 || if_ready !== 1'b0 || if_valid !== 1'b0) begin
            n_fail++; $display("FAIL pause_frozen[%0d]: got ena=%b addr=%h ready=%b valid=%b, required 1/00004010/0/0",
                               i, mc_fet_ena, mc_addr, if_ready, if_valid);
         end
      end
      mc_valid = 1'b0;
      rdy = 1'b1;
      step();
      n_cmp++; if (mc_fet_ena !== 1'b1) begin n_fail++; $display("FAIL pause_resume: got ena=%b, required 1", mc_fet_ena); end
      sb.push_back(32'h4444_0010);
      fill(32'h4444_0010, 0);
      drain("pause_miss");
      // A hit response frozen by rdy is reported once when rdy returns.
      sb.push_back(32'h4444_0010);
      req(32'h0000_4010);
      rdy = 1'b0;
      step(); step();
      n_cmp++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL pause_hold_valid: got %b, required 1", if_valid); end
      rdy = 1'b1;
      drain("pause_hit");
   endtask

   task automatic test_reset_mid_miss();
      req(32'h0000_5014);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_cmp++; if (mc_fet_ena !== 1'b0 || if_ready !== 1'b1) begin
         n_fail++; $display("FAIL rst_mid_miss: got ena=%b ready=%b, required 0/1", mc_fet_ena, if_ready);
      end
      mc_valid = 1'b1; mc_data = 32'h5555_5555;
      step();
      mc_valid = 1'b0;
      n_cmp++; if (if_valid !== 1'b0 || mc_fet_ena !== 1'b0) begin
         n_fail++; $display("FAIL rst_late_mc_valid: got valid=%b ena=%b, required 0/0", if_valid, mc_fet_ena);
      end
      req(32'h0000_1004);
      n_cmp++; if (mc_fet_ena !== 1'b1) begin n_fail++; $display("FAIL rst_invalidates: got ena=%b, required 1", mc_fet_ena); end
      sb.push_back(32'h00A0_0093);
      fill(32'h00A0_0093, 1);
      drain("rst");
   endtask

   task automatic test_bypass();
      for (int i = 0; i < 3; i++) begin
         sb.push_back(32'hB0B0_0000 + i);
         req(32'h0000_1004);
         n_cmp++; if (mc_fet_ena !== 1'b1 || mc_addr !== 32'h0000_1004) begin
            n_fail++; $display("FAIL bypass_miss[%0d]: got ena=%b addr=%h, required 1/00001004", i, mc_fet_ena, mc_addr);
         end
         fill(32'hB0B0_0000 + i, 1);
      end
      drain("bypass");
   endtask

   initial begin
      test_reset();
      test_cold_miss();
`ifdef ICACHE_BYPASS_EN
      test_bypass();
`else
      test_hit();
      test_conflict();
      test_clear();
      test_pause();
      test_reset_mid_miss();
`endif
      repeat (2) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, word-per-line instruction cache between the instruction-fetch stage and the memory controller. Registered lookup: hits return one cycle after the request. Misses issue a single-word fetch to the memory controller, hold it until the controller's one-cycle valid pulse, fill the line, then return the word. Supports fetch-redirect (clear) and the global `rdy` pause.

## Interface
- `INDEX_WIDTH`, default 8: line index bits; the cache holds 2^INDEX_WIDTH lines of one 32-bit word each.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `rdy` in 1: global ready; low freezes all state and outputs.
- `if_req` in 1: fetch request; sampled only when `if_ready`=1.
- `if_pc` in 32: fetch address; bits [1:0] ignored.
- `if_clear` in 1: redirect; cancels any outstanding response.
- `if_ready` out 1: high in IDLE (combinational from state).
- `if_valid` out 1: one-cycle pulse; `if_instr` is valid.
- `if_instr` out 32: fetched instruction.
- `mc_fet_ena` out 1: fetch request to the memory controller (registered).
- `mc_addr` out 32: word-aligned fetch address (registered).
- `mc_valid` in 1: one-cycle pulse; `mc_data` carries the full word.
- `mc_data` in 32: fetched word from the memory controller.

## Operation
- Address split:
  - offset = pc[1:0] (dropped).
  - index = pc[INDEX_WIDTH+1:2].
  - tag = pc[31:INDEX_WIDTH+2].
- Storage: valid bit array, tag array, data array. All valid bits are cleared on `rst`; tags and data are not reset.
- Reset values: state=IDLE; `if_valid`=0, `if_instr`=0, `mc_fet_ena`=0, `mc_addr`=0. Internal `pend_pc`=0, `drop`=0.
- State IDLE:
  - `if_req` && !`if_clear` && hit → next cycle `if_valid`=1, `if_instr`=data[index]; stay IDLE.
  - `if_req` && !`if_clear` && miss → capture `pend_pc`; next cycle `mc_fet_ena`=1, `mc_addr`={pc[31:2],2'b00}, state=MISS, `drop`=0.
  - `if_clear` (with or without `if_req`) → request dropped; `if_valid`=0 next cycle.
- State MISS:
  - `mc_fet_ena` and `mc_addr` are held stable until `mc_valid`.
  - `if_clear` sets `drop`=1. The memory request is never aborted, because the controller has no abort.
  - On `mc_valid`:
    - write tag, data and valid=1 at `pend_pc` index.
    - `mc_fet_ena`←0; state←IDLE.
    - `if_valid`←!`drop` && !`if_clear`; `if_instr`←`mc_data`.
- `if_valid` is deasserted every cycle it is not explicitly set (pulse semantics).
- A fill overwrites the existing line at that index regardless of its valid or tag.
- A request in the cycle right after a fill to the same index sees the new line (array write completes at the fill edge).
- `rdy`=0: no state, array or output register changes. `mc_valid` is not sampled; the controller is paused identically.
- `rst` mid-MISS: immediate return to IDLE, `mc_fet_ena`=0, all lines invalid. A late `mc_valid` in IDLE is ignored.

## Timing
- Hit latency: `if_req` at edge N → `if_valid` high in cycle N+1.
- Miss latency: `mc_fet_ena` rises at N+1. `mc_valid` arrives at edge M. `if_valid` is high in cycle M+1. `if_ready` is high again in cycle M+1.
- At most one outstanding memory request. `if_ready`=0 throughout MISS; the fetch stage must hold its request until `if_ready`=1.
- `mc_fet_ena` drops in the cycle after `mc_valid`, so no back-to-back re-request of the same address.

## Configuration
- `ICACHE_BYPASS_EN` defined:
  - arrays are not instantiated; every request is treated as a miss.
  - fills write nothing; all timing equals the miss path.
  - `INDEX_WIDTH` is unused.
- `ICACHE_BYPASS_EN` undefined: normal direct-mapped cache as above.

## Test plan
- Cold miss: after reset, `if_req` pc=0x0000_1004.
  - Expect `mc_fet_ena`=1, `mc_addr`=0x0000_1004.
  - Drive `mc_valid` with 0x00A0_0093 three cycles later → `if_valid` pulse, `if_instr`=0x00A0_0093.
- Hit: re-request 0x0000_1004 → `if_valid` the next cycle with 0x00A0_0093 and no `mc_fet_ena`.
- Conflict: pc=0x0000_1004, then 0x0000_1404 (same index, INDEX_WIDTH=8).
  - Second request misses and refills.
  - Third request, 0x0000_1004, misses again.
- Clear during miss: `if_clear` two cycles after `mc_fet_ena` rises.
  - `mc_addr` stays stable; `mc_valid` → no `if_valid`.
  - Next request to the same pc hits.
- Pause and reset:
  - `rdy`=0 for 5 cycles mid-miss → outputs frozen.
  - `rst` mid-miss → `mc_fet_ena`=0 next cycle, `if_ready`=1; prior hit addresses now miss.
- Bypass build: repeated requests to one pc each assert `mc_fet_ena`.
